bp_cce_lce_req_sink: RTL and testbench
======================================

Name: bp_cce_lce_req_sink

Overview:
- CCE-side receiver for the LCE request network, using the BedRock burst protocol with ready&valid on separate header and data channels.
- Accepts one request header plus zero or more fill-width data beats and assembles them into a full-block message buffer.
- Presents header and assembled data to the CCE directory FSM with a valid->yumi handshake.
- Holds one message at a time, with a same-cycle handoff when the consumer drains the buffer.

Parameters:
- header_width_p, 128: width of the BedRock LCE request header, treated as opaque.
- fill_width_p, 64: data channel beat width in bits.
- block_width_p, 512: maximum assembled payload width in bits.
- data_els_lp, block_width_p/fill_width_p: beats per block; localparam, must be ≥1.
- cnt_width_lp, `BSG_SAFE_CLOG2(data_els_lp+1)`: width of the beat counter.

Ports:
- clk_i, input, 1: clock.
- reset_n_i, input, 1: asynchronous active-low reset.
- lce_req_header_i, input, header_width_p: incoming request header.
- lce_req_header_v_i, input, 1: header valid.
- lce_req_header_ready_and_o, output, 1: header ready.
- lce_req_has_data_i, input, 1: header is followed by data beats; qualified by header valid.
- lce_req_data_i, input, fill_width_p: data beat.
- lce_req_data_v_i, input, 1: data beat valid.
- lce_req_data_ready_and_o, output, 1: data ready.
- lce_req_last_i, input, 1: final data beat of the message; qualified by data valid.
- req_header_o, output, header_width_p: captured header.
- req_data_o, output, block_width_p: assembled data; beat k occupies bits [k*fill_width_p +: fill_width_p].
- req_beats_o, output, cnt_width_lp: number of beats received, 0 to data_els_lp.
- req_v_o, output, 1: assembled message valid.
- req_yumi_i, input, 1: consumer takes the message; legal only while req_v_o=1.
- protocol_error_o, output, 1: sticky overrun error.

Behaviour:
- Reset (reset_n_i low, asynchronous):
  - State goes to e_idle.
  - Header, data buffer and beat counter go to 0.
  - protocol_error_o goes to 0.
  - All outputs read 0 except lce_req_header_ready_and_o, which reads 1 once state is e_idle.
  - Reset asserted mid-message discards the partial message with no output pulse.
- States: e_idle, e_data, e_full.
- e_idle:
  - lce_req_header_ready_and_o=1, lce_req_data_ready_and_o=0, req_v_o=0.
  - Header handshake: capture the header, clear the data buffer to all zeros, clear the counter.
  - Next state is e_data if lce_req_has_data_i, else e_full.
- e_data:
  - lce_req_data_ready_and_o=1, header ready=0.
  - Data handshake: write the beat into slot cnt, then cnt<=cnt+1.
  - If lce_req_last_i, next state is e_full.
  - If the beat fills slot data_els_lp-1 without last: set protocol_error_o and go to e_full. Further beats stay unaccepted until the buffer is drained.
- e_full:
  - req_v_o=1; req_header_o, req_data_o and req_beats_o are stable until yumi.
  - On req_yumi_i, next state is e_idle.
  - lce_req_header_ready_and_o = req_yumi_i (combinational). A header presented in the yumi cycle is captured and replaces the buffer contents next cycle, so back-to-back headerless messages sustain one message per cycle.
  - Data ready=0.
- Latency:
  - Header-only message: req_v_o rises the cycle after the header handshake.
  - N-beat message: req_v_o rises the cycle after the last beat handshake.
- Beats not received read zero in req_data_o.
- Data valid while in e_idle or e_full is not accepted; it is held off by ready=0.
- req_yumi_i while req_v_o=0 is ignored.
- protocol_error_o is cleared only by reset.

Optional Feature:
- Macro: BP_CCE_REQ_SINK_STATS_EN.
- With the macro defined: add outputs stat_msgs_o [31:0] and stat_beats_o [31:0].
  - stat_msgs_o counts yumi'd messages.
  - stat_beats_o counts accepted data beats.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Without the macro: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Header-only:
  - Stimulus: header 0xA5 with has_data=0.
  - Response: req_v_o=1 next cycle, req_beats_o=0, req_data_o=0.
  - After yumi: back in e_idle, header ready=1.
- Single-beat uncached store:
  - Stimulus: header plus one beat 0xDEADBEEF_01234567 with last=1.
  - Response: req_data_o[63:0]=0xDEADBEEF_01234567, upper bits 0, req_beats_o=1.
- Full block:
  - Stimulus: 8 beats of value k+1 with last on beat 7 and random data_v gaps.
  - Response: slot k = k+1, req_beats_o=8, protocol_error_o=0.
- Overrun:
  - Stimulus: 8 beats with no last.
  - Response: protocol_error_o=1 after beat 8, req_v_o=1, a 9th beat stays un-acked; error persists after yumi.
- Back-to-back:
  - Stimulus: headers H1, H2 both header-only, with yumi every cycle.
  - Response: H2 accepted in H1's yumi cycle, req_v_o high for 2 consecutive cycles, H1 then H2.
- Async reset:
  - Stimulus: assert reset_n_i low between data beats 3 and 4.
  - Response: req_v_o=0 and counter=0 immediately; the next header is accepted cleanly.
  - With BP_CCE_REQ_SINK_STATS_EN: stat counters read 0.

Source files
------------

// File: rtl/bp_cce_lce_req_sink.sv
// CCE-side LCE request sink: collects one header plus burst data beats
// into a block buffer and offers it to the directory FSM (valid->yumi).
//
// Ports:
//   clk_i, reset_n_i              clock, async active-low reset
//   lce_req_header_*              header channel (ready&valid), has_data
//   lce_req_data_*                fill-width data channel (ready&valid), last
//   req_header_o/req_data_o       captured header, assembled block
//   req_beats_o, req_v_o          beats received, message valid
//   req_yumi_i                    consumer takes message
//   protocol_error_o              sticky overrun flag
// Optional: define BP_CCE_REQ_SINK_STATS_EN to add stat_msgs_o and
// stat_beats_o saturating counters.

module bp_cce_lce_req_sink #(
  parameter int header_width_p = 128,
  parameter int fill_width_p   = 64,
  parameter int block_width_p  = 512,
  localparam int data_els_lp   = block_width_p / fill_width_p,
  localparam int cnt_width_lp  =
    (data_els_lp + 1 > 1) ? $clog2(data_els_lp + 1) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,

  input  logic [header_width_p-1:0] lce_req_header_i,
  input  logic                      lce_req_header_v_i,
  output logic                      lce_req_header_ready_and_o,
  input  logic                      lce_req_has_data_i,

  input  logic [fill_width_p-1:0]   lce_req_data_i,
  input  logic                      lce_req_data_v_i,
  output logic                      lce_req_data_ready_and_o,
  input  logic                      lce_req_last_i,

  output logic [header_width_p-1:0] req_header_o,
  output logic [block_width_p-1:0]  req_data_o,
  output logic [cnt_width_lp-1:0]   req_beats_o,
  output logic                      req_v_o,
  input  logic                      req_yumi_i,
`ifdef BP_CCE_REQ_SINK_STATS_EN
  output logic [31:0]               stat_msgs_o,
  output logic [31:0]               stat_beats_o,
`endif
  output logic                      protocol_error_o
);

  typedef enum logic [1:0] {
    e_idle,
    e_data,
    e_full
  } state_e;

  localparam logic [cnt_width_lp-1:0] last_slot_lp =
    cnt_width_lp'(data_els_lp - 1);

  state_e                    state_q, state_d;
  logic [header_width_p-1:0] header_q, header_d;
  logic [block_width_p-1:0]  data_q, data_d;
  logic [cnt_width_lp-1:0]   cnt_q, cnt_d;
  logic                      err_q, err_d;

  logic hdr_rdy, data_rdy, full;
  logic hdr_fire, data_fire;

  always_comb begin
    state_d  = state_q;
    header_d = header_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    hdr_rdy  = 1'b0;
    data_rdy = 1'b0;
    full     = 1'b0;

    unique case (state_q)
      e_idle: hdr_rdy = 1'b1;
      e_data: data_rdy = 1'b1;
      e_full: begin
        full = 1'b1;
        // Same-cycle handoff: a new header may enter as the old leaves.
        hdr_rdy = req_yumi_i;
        if (req_yumi_i) state_d = e_idle;
      end
      default: state_d = e_idle;
    endcase

    hdr_fire  = hdr_rdy & lce_req_header_v_i;
    data_fire = data_rdy & lce_req_data_v_i;

    if (hdr_fire) begin
      header_d = lce_req_header_i;
      data_d   = '0;
      cnt_d    = '0;
      state_d  = lce_req_has_data_i ? e_data : e_full;
    end

    if (data_fire) begin
      for (int k = 0; k < data_els_lp; k++) begin
        if (cnt_q == cnt_width_lp'(k))
          data_d[k*fill_width_p +: fill_width_p] = lce_req_data_i;
      end
      cnt_d = cnt_q + cnt_width_lp'(1);
      if (lce_req_last_i) begin
        state_d = e_full;
      end else if (cnt_q == last_slot_lp) begin
        // Buffer full but sender still streaming: flag and stop.
        err_d   = 1'b1;
        state_d = e_full;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= e_idle;
      header_q <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      header_q <= header_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign lce_req_header_ready_and_o = hdr_rdy;
  assign lce_req_data_ready_and_o   = data_rdy;
  assign req_v_o                    = full;
  assign req_header_o               = header_q;
  assign req_data_o                 = data_q;
  assign req_beats_o                = cnt_q;
  assign protocol_error_o           = err_q;

`ifdef BP_CCE_REQ_SINK_STATS_EN
  logic [31:0] msgs_q, beats_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      msgs_q  <= '0;
      beats_q <= '0;
    end else begin
      if (full & req_yumi_i & ~&msgs_q)
        msgs_q <= msgs_q + 32'd1;
      if (data_fire & ~&beats_q)
        beats_q <= beats_q + 32'd1;
    end
  end

  assign stat_msgs_o  = msgs_q;
  assign stat_beats_o = beats_q;
`endif

endmodule

// File: tb/tb_bp_cce_lce_req_sink.sv
// Scoreboard bench for bp_cce_lce_req_sink: directed messages push
// expected results; a monitor pops and compares on each req_v_o.

module tb_bp_cce_lce_req_sink;

  localparam int HW = 128;
  localparam int FW = 64;
  localparam int BW = 512;

  typedef struct {
    logic [HW-1:0] hdr;
    logic [BW-1:0] data;
    logic [3:0]    beats;
    logic          err;
  } exp_t;

  logic          clk = 0;
  logic          rst_n = 0;
  logic [HW-1:0] hdr_i = '0;
  logic          hdr_v = 0;
  logic          hdr_rdy;
  logic          has_data = 0;
  logic [FW-1:0] data_i = '0;
  logic          data_v = 0;
  logic          data_rdy;
  logic          last = 0;
  logic [HW-1:0] req_hdr;
  logic [BW-1:0] req_data;
  logic [3:0]    req_beats;
  logic          req_v;
  logic          yumi = 0;
  logic          perr;
`ifdef BP_CCE_REQ_SINK_STATS_EN
  logic [31:0]   st_msgs, st_beats;
`endif

  bp_cce_lce_req_sink dut (
    .clk_i                      (clk),
    .reset_n_i                  (rst_n),
    .lce_req_header_i           (hdr_i),
    .lce_req_header_v_i         (hdr_v),
    .lce_req_header_ready_and_o (hdr_rdy),
    .lce_req_has_data_i         (has_data),
    .lce_req_data_i             (data_i),
    .lce_req_data_v_i           (data_v),
    .lce_req_data_ready_and_o   (data_rdy),
    .lce_req_last_i             (last),
    .req_header_o               (req_hdr),
    .req_data_o                 (req_data),
    .req_beats_o                (req_beats),
    .req_v_o                    (req_v),
    .req_yumi_i                 (yumi),
`ifdef BP_CCE_REQ_SINK_STATS_EN
    .stat_msgs_o                (st_msgs),
    .stat_beats_o               (st_beats),
`endif
    .protocol_error_o           (perr)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic yumi_en = 1;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: yumi the presented message and compare with queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && req_v && yumi_en) begin
        if (q.size() == 0) begin
          chk("unexpected_msg", {511'b0, req_v}, '0);
        end else begin
          e = q.pop_front();
          chk("mon_hdr", BW'(req_hdr), BW'(e.hdr));
          chk("mon_data", req_data, e.data);
          chk("mon_beats", BW'(req_beats), BW'(e.beats));
          chk("mon_err", BW'(perr), BW'(e.err));
        end
        yumi = 1;
        @(posedge clk);
        #1 yumi = 0;
      end
    end
  end

  // Returns at posedge+1 of the accepting edge.
  task automatic send_hdr(logic [HW-1:0] h, logic hd, output int acc);
    logic f;
    f = 0;
    hdr_i = h; has_data = hd; hdr_v = 1;
    for (int i = 0; i < 50 && !f; i++) begin
      @(negedge clk); #2 f = hdr_rdy;
      @(posedge clk); #1;
    end
    acc = cyc;
    hdr_v = 0; has_data = 0;
    if (!f) chk("hdr_timeout", 1, 0);
  endtask

  task automatic send_beat(logic [FW-1:0] d, logic l, int gap);
    logic f;
    f = 0;
    repeat (gap) @(posedge clk);
    #1;
    data_i = d; last = l; data_v = 1;
    for (int i = 0; i < 50 && !f; i++) begin
      @(negedge clk); #2 f = data_rdy;
      @(posedge clk); #1;
    end
    data_v = 0; last = 0;
    if (!f) chk("beat_timeout", 1, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) chk("drain_timeout", BW'(q.size()), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    int a1, a2;

    // Reset state
    #3;
    chk("rst_v", BW'(req_v), 0);
    chk("rst_hrdy", BW'(hdr_rdy), 1);
    chk("rst_drdy", BW'(data_rdy), 0);
    chk("rst_err", BW'(perr), 0);
    chk("rst_beats", BW'(req_beats), 0);
    chk("rst_data", req_data, 0);
    chk("rst_hdr", BW'(req_hdr), 0);
`ifdef BP_CCE_REQ_SINK_STATS_EN
    chk("rst_smsg", BW'(st_msgs), 0);
    chk("rst_sbeat", BW'(st_beats), 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;

    // Header-only
    e.hdr = 'hA5; e.data = '0; e.beats = 0; e.err = 0;
    q.push_back(e);
    send_hdr('hA5, 0, a1);
    chk("ho_latency", BW'(req_v), 1);
    drain();
    chk("ho_idle_hrdy", BW'(hdr_rdy), 1);
    chk("ho_idle_v", BW'(req_v), 0);

    // Single-beat store
    e.hdr = 'h1111; e.data = '0;
    e.data[63:0] = 64'hDEADBEEF_01234567;
    e.beats = 1; e.err = 0;
    q.push_back(e);
    send_hdr('h1111, 1, a1);
    chk("sb_v_early", BW'(req_v), 0);
    send_beat(64'hDEADBEEF_01234567, 1, 0);
    chk("sb_latency", BW'(req_v), 1);
    drain();

    // Full block, random gaps
    e.hdr = 'h2222; e.beats = 8; e.err = 0;
    for (int k = 0; k < 8; k++) e.data[k*FW +: FW] = FW'(k + 1);
    q.push_back(e);
    send_hdr('h2222, 1, a1);
    for (int k = 0; k < 8; k++)
      send_beat(FW'(k + 1), k == 7, $urandom_range(0, 2));
    chk("fb_v", BW'(req_v), 1);
    chk("fb_err", BW'(perr), 0);
    drain();

    // Back-to-back header-only
    e.hdr = 'hB1; e.data = '0; e.beats = 0; e.err = 0;
    q.push_back(e);
    e.hdr = 'hB2;
    q.push_back(e);
    send_hdr('hB1, 0, a1);
    send_hdr('hB2, 0, a2);
    chk("b2b_gap", BW'(a2 - a1), 1);
    chk("b2b_v", BW'(req_v), 1);
    chk("b2b_hdr", BW'(req_hdr), 'hB2);
    drain();

    // Overrun
    yumi_en = 0;
    e.hdr = 'hC3; e.beats = 8; e.err = 1;
    for (int k = 0; k < 8; k++) e.data[k*FW +: FW] = FW'(k + 'h10);
    q.push_back(e);
    send_hdr('hC3, 1, a1);
    for (int k = 0; k < 8; k++) send_beat(FW'(k + 'h10), 0, 0);
    chk("ov_err", BW'(perr), 1);
    chk("ov_v", BW'(req_v), 1);
    data_i = 64'h99; data_v = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ov_9th_rdy", BW'(data_rdy), 0);
    end
    chk("ov_beats_held", BW'(req_beats), 8);
    data_v = 0;
    yumi_en = 1;
    drain();
    chk("ov_err_sticky", BW'(perr), 1);

    // Async reset mid-message
    send_hdr('hD4, 1, a1);
    for (int k = 0; k < 3; k++) send_beat(FW'(k + 'h40), 0, 0);
    #2 rst_n = 0;
    #1;
    chk("ar_v", BW'(req_v), 0);
    chk("ar_beats", BW'(req_beats), 0);
    chk("ar_err", BW'(perr), 0);
    chk("ar_data", req_data, 0);
    chk("ar_hrdy", BW'(hdr_rdy), 1);
`ifdef BP_CCE_REQ_SINK_STATS_EN
    chk("ar_smsg", BW'(st_msgs), 0);
    chk("ar_sbeat", BW'(st_beats), 0);
`endif
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    e.hdr = 'hE5; e.data = '0; e.beats = 0; e.err = 0;
    q.push_back(e);
    send_hdr('hE5, 0, a1);
    chk("ar_next_v", BW'(req_v), 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
